bomberman_controller: RTL and testbench
=======================================

# bomberman_controller

Registered player-position controller for the Bomberman sprite. It decodes the direction buttons and the per-direction blocked flags from the wall/box collision logic. On a fixed move tick it steps the player one pixel at a time, keeping the player inside the playfield bounds. Its registered position feeds the box collision instances and the pixel renderer, and it also drives facing and walk-animation outputs for sprite selection.

## Interface
- X_MIN, 0: leftmost legal b_x
- X_MAX, 624: rightmost legal b_x (640 − 16)
- Y_MIN, 0: topmost legal b_y
- Y_MAX, 464: bottommost legal b_y (480 − 16)
- START_X, 16: b_x after reset
- START_Y, 16: b_y after reset
- MOVE_DIV, 1_000_000: clk cycles per move tick, ≥2
- ANIM_STEPS, 4: successful pixel steps per animation frame advance, ≥1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn  in  4  direction buttons, [3]=up [2]=down [1]=left [0]=right, level, pre-debounced
- blocked  in  4  OR of all box bomberman_blocked outputs, same bit mapping
- b_x  out  10  player x, top-left of 16×16 sprite
- b_y  out  10  player y
- facing  out  2  0=down 1=up 2=left 3=right
- walking  out  1  FSM in WALK
- anim_frame  out  2  walk animation frame
- move_tick  out  1  one-cycle pulse, step strobe

## Operation
- Reset: when reset=0, all outputs are forced immediately and asynchronously:
  - b_x=START_X, b_y=START_Y
  - facing=0, walking=0, anim_frame=0, move_tick=0
  - tick counter=0, step counter=0, FSM=IDLE
- Direction select: fixed priority up > down > left > right. Opposite or multiple presses resolve to the highest-priority set bit. No bit set means no direction.
- FSM IDLE:
  - If any btn bit is set, go to WALK on the next edge.
  - facing loads the selected direction on that same edge.
- FSM WALK:
  - If btn==0, go to IDLE. anim_frame and the step counter clear to 0.
  - Otherwise facing tracks the selected direction every cycle, including when that direction is blocked.
- Step, evaluated only in the cycle move_tick=1 while in WALK:
  - Target is position ±1 on the selected axis.
  - Move only if blocked[sel]=0 and the target lies within [X_MIN,X_MAX] / [Y_MIN,Y_MAX].
  - Otherwise the position holds, with no wrap and no overshoot.
  - Bounds are checked before the add/subtract, so there is no 10-bit underflow at 0.
- Animation:
  - Each successful step increments the step counter.
  - When the counter reaches ANIM_STEPS−1 and a step occurs, it clears and anim_frame increments mod 4 (3→0).
  - A blocked or out-of-bounds tick does not count.
- Tick generator: free-running counter 0..MOVE_DIV−1, independent of FSM state. move_tick=1 exactly when the counter equals MOVE_DIV−1.

## Timing
- All outputs are registered.
- btn and blocked are sampled at the rising edge closing the move_tick cycle.
  - b_x/b_y update on that edge, one-cycle latency from the tick.
- IDLE→WALK takes effect on the first edge with btn≠0.
  - A tick in that same cycle does not step, because the FSM is still IDLE.
- blocked is treated as combinational from the current b_x/b_y. Its value in the tick cycle is authoritative.
- A button released in the tick cycle means no step: WALK→IDLE and the position holds.
- Reset deassertion is asynchronous. The first tick occurs MOVE_DIV cycles after release.

## Structure
- Shared package `bomberman_pkg`:
  - direction bit indices DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0
  - facing codes FACE_DOWN/UP/LEFT/RIGHT
  - TILE_W=16, TILE_H=16
  - screen size 640×480
  - FSM state typedef {IDLE, WALK}
- Sub-module `tick_gen` (parameter DIV, outputs pulse), which the animation logic can reuse later.
- Top level is the FSM, priority encoder, bounds/step datapath and animation counter.

## Test plan
Bench uses MOVE_DIV=4, ANIM_STEPS=2.
- Reset and release, btn=0 for 40 cycles -> b_x=16, b_y=16, walking=0, facing=0; move_tick pulses every 4 cycles.
- btn=0001 (right), blocked=0 held for 10 ticks -> b_x=26, b_y=16, facing=3, walking=1, anim_frame=1 (5 frame advances, mod 4).
- btn=0010 (left) with blocked=0010 for 5 ticks -> b_x unchanged, facing=2, anim_frame unchanged.
- Start at X_MIN via START_X=0, press left for 3 ticks -> b_x stays 0, no underflow to 1023. Start at b_x=624, press right -> stays 624.
- btn=1100 (up+down) for 3 ticks -> b_y=13, facing=1. Then btn=0 -> walking=0 and anim_frame=0 next edge.
- Assert reset=0 mid-walk between clock edges -> outputs return to reset values before the next clk edge and hold while reset=0.

Source files
------------

// File: rtl/bomberman_pkg.sv
// bomberman_pkg: shared direction/facing codes, screen geometry and FSM state type.
package bomberman_pkg;
  localparam int DIR_UP = 3;
  localparam int DIR_DOWN = 2;
  localparam int DIR_LEFT = 1;
  localparam int DIR_RIGHT = 0;
  localparam logic [1:0] FACE_DOWN = 2'd0;
  localparam logic [1:0] FACE_UP = 2'd1;
  localparam logic [1:0] FACE_LEFT = 2'd2;
  localparam logic [1:0] FACE_RIGHT = 2'd3;
  localparam int TILE_W = 16;
  localparam int TILE_H = 16;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef enum logic {IDLE, WALK} state_t;
endpackage

// File: rtl/bomberman_controller_if.sv
// bomberman_controller_if: button/collision inputs and sprite state outputs of the player controller.
interface bomberman_controller_if;
  logic [3:0] btn;
  logic [3:0] blocked;
  logic [9:0] b_x;
  logic [9:0] b_y;
  logic [1:0] facing;
  logic walking;
  logic [1:0] anim_frame;
  logic move_tick;
  modport master (output btn, blocked, input b_x, b_y, facing, walking, anim_frame, move_tick);
  modport slave (input btn, blocked, output b_x, b_y, facing, walking, anim_frame, move_tick);
endinterface

// File: rtl/bomberman_controller_tick_gen.sv
// tick_gen: free-running divider emitting a registered one-cycle pulse every DIV clocks.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pulse
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] r_cnt;
  logic r_pulse;
  // pulse is raised one edge early so it coincides with r_cnt == DIV-1
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == W'(DIV - 1)) ? '0 : r_cnt + W'(1);
      r_pulse <= (r_cnt == W'(DIV - 2));
    end
  assign pulse = r_pulse;
endmodule

// File: rtl/bomberman_controller.sv
// bomberman_controller: button-driven player position FSM with bounds/collision stepping and walk animation.
module bomberman_controller
  import bomberman_pkg::*;
#(
  parameter int X_MIN = 0,
  parameter int X_MAX = SCREEN_W - TILE_W,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = SCREEN_H - TILE_H,
  parameter int START_X = 16,
  parameter int START_Y = 16,
  parameter int MOVE_DIV = 1_000_000,
  parameter int ANIM_STEPS = 4
) (
  input logic clk,
  input logic reset,
  bomberman_controller_if.slave bus
);
  localparam int SW = $clog2(ANIM_STEPS + 1);
  state_t r_state, w_next;
  logic [9:0] r_x, r_y;
  logic [1:0] r_face, r_frame, w_dir;
  logic [SW-1:0] r_steps;
  logic w_tick, w_any, w_blk, w_inb, w_step, w_wrap;
  tick_gen #(.DIV(MOVE_DIV)) u_tick (.clk(clk), .reset(reset), .pulse(w_tick));
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  // bounds are compared before the step so x/y never pass through 0-1
  always_comb begin
    w_any = |bus.btn;
    w_next = w_any ? WALK : IDLE;
    w_dir = bus.btn[DIR_UP] ? FACE_UP : bus.btn[DIR_DOWN] ? FACE_DOWN :
            bus.btn[DIR_LEFT] ? FACE_LEFT : FACE_RIGHT;
    w_blk = bus.btn[DIR_UP] ? bus.blocked[DIR_UP] : bus.btn[DIR_DOWN] ? bus.blocked[DIR_DOWN] :
            bus.btn[DIR_LEFT] ? bus.blocked[DIR_LEFT] : bus.blocked[DIR_RIGHT];
    w_inb = bus.btn[DIR_UP] ? (r_y > 10'(Y_MIN)) : bus.btn[DIR_DOWN] ? (r_y < 10'(Y_MAX)) :
            bus.btn[DIR_LEFT] ? (r_x > 10'(X_MIN)) : (r_x < 10'(X_MAX));
    w_step = (r_state == WALK) && w_tick && w_any && !w_blk && w_inb;
    w_wrap = (r_steps == SW'(ANIM_STEPS - 1));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_x <= 10'(START_X);
      r_y <= 10'(START_Y);
      r_face <= FACE_DOWN;
      r_frame <= 2'd0;
      r_steps <= '0;
    end else begin
      if (w_any) r_face <= w_dir;
      if (r_state == WALK && !w_any) begin
        r_frame <= 2'd0;
        r_steps <= '0;
      end else if (w_step) begin
        r_steps <= w_wrap ? '0 : r_steps + SW'(1);
        r_frame <= w_wrap ? r_frame + 2'd1 : r_frame;
      end
      r_x <= (w_step && w_dir == FACE_LEFT) ? r_x - 10'd1 :
             (w_step && w_dir == FACE_RIGHT) ? r_x + 10'd1 : r_x;
      r_y <= (w_step && w_dir == FACE_UP) ? r_y - 10'd1 :
             (w_step && w_dir == FACE_DOWN) ? r_y + 10'd1 : r_y;
    end
  assign bus.b_x = r_x;
  assign bus.b_y = r_y;
  assign bus.facing = r_face;
  assign bus.walking = (r_state == WALK);
  assign bus.anim_frame = r_frame;
  assign bus.move_tick = w_tick;
endmodule

// File: tb/tb_bomberman_controller.sv
// tb_bomberman_controller: directed checks of reset, stepping, blocking, bounds, priority and async reset.
module tb_bomberman_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  bomberman_controller_if bif ();
  bomberman_controller #(.MOVE_DIV(4), .ANIM_STEPS(2)) dut (.clk(clk), .reset(reset), .bus(bif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic run_ticks(input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n && guard < 10000) begin
      @(negedge clk);
      guard++;
      if (bif.move_tick) seen++;
    end
    if (seen < n) chk("tick_timeout", seen, n);
    @(negedge clk);
  endtask
  task automatic align_tick();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bif.move_tick && guard < 100);
    if (!bif.move_tick) chk("align_timeout", 0, 1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, bif.b_x, 16);
    chk({tag, "_y"}, bif.b_y, 16);
    chk({tag, "_face"}, bif.facing, 0);
    chk({tag, "_walk"}, bif.walking, 0);
    chk({tag, "_frame"}, bif.anim_frame, 0);
    chk({tag, "_tick"}, bif.move_tick, 0);
  endtask
  initial begin
    int ticks, last, gaps_bad;
    bif.btn = 4'b0000;
    bif.blocked = 4'b0000;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset = 1'b1;
    ticks = 0;
    last = -1;
    gaps_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bif.move_tick) begin
        if (last >= 0 && i - last != 4) gaps_bad++;
        last = i;
        ticks++;
      end
    end
    chk("idle_ticks", ticks, 10);
    chk("tick_gap_bad", gaps_bad, 0);
    chk("idle_x", bif.b_x, 16);
    chk("idle_y", bif.b_y, 16);
    chk("idle_walk", bif.walking, 0);
    chk("idle_face", bif.facing, 0);
    align_tick();
    bif.btn = 4'b0001;
    run_ticks(10);
    chk("right_x", bif.b_x, 26);
    chk("right_y", bif.b_y, 16);
    chk("right_face", bif.facing, 3);
    chk("right_walk", bif.walking, 1);
    chk("right_frame", bif.anim_frame, 1);
    bif.btn = 4'b0010;
    bif.blocked = 4'b0010;
    run_ticks(5);
    chk("blk_x", bif.b_x, 26);
    chk("blk_face", bif.facing, 2);
    chk("blk_frame", bif.anim_frame, 1);
    bif.blocked = 4'b0000;
    run_ticks(29);
    chk("left_min_x", bif.b_x, 0);
    chk("left_min_frame", bif.anim_frame, 2);
    bif.btn = 4'b0001;
    run_ticks(627);
    chk("right_max_x", bif.b_x, 624);
    chk("right_max_frame", bif.anim_frame, 2);
    bif.btn = 4'b1100;
    run_ticks(3);
    chk("updown_y", bif.b_y, 13);
    chk("updown_x", bif.b_x, 624);
    chk("updown_face", bif.facing, 1);
    chk("updown_frame", bif.anim_frame, 3);
    bif.btn = 4'b0000;
    @(negedge clk);
    chk("release_walk", bif.walking, 0);
    chk("release_frame", bif.anim_frame, 0);
    chk("release_face", bif.facing, 1);
    bif.btn = 4'b0010;
    run_ticks(2);
    chk("pre_rst_walk", bif.walking, 1);
    #2 reset = 1'b0;
    #1 chk_reset("async");
    repeat (3) @(negedge clk);
    chk_reset("hold");
    bif.btn = 4'b0000;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
